// File: rtl/axi_pkg.sv
// Shared AXI types for the slave memory model.
// Burst/response encodings and channel FSM states.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  // WRAP and the reserved encoding are refused, as is any narrow size.
  function automatic logic cfg_bad(
    input logic [1:0] burst,
    input logic [2:0] size,
    input logic [2:0] size_ok
  );
    return (burst != BURST_FIXED && burst != BURST_INCR) ||
           (size != size_ok);
  endfunction

endpackage

// File: rtl/axi_slave_mem_ram.sv
// Word RAM: one byte-enabled write port, one read port
// with a registered read-load strobe.
module axi_slave_mem_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (wstrb[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Same-cycle write to the loaded word returns the old contents.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave memory: independent write and read FSMs,
// one outstanding transaction per direction.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = 10,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_STRB_WIDTH = C_AXI_DATA_WIDTH/8,
  parameter int C_AXI_LEN_WIDTH  = 8,
  parameter int MEM_DEPTH        = 1024
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESET_N,
  input  logic [C_AXI_ID_WIDTH-1:0]   AXI_AWID,
  input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_AWADDR,
  input  logic [C_AXI_LEN_WIDTH-1:0]  AXI_AWLEN,
  input  logic [2:0]                  AXI_AWSIZE,
  input  logic [1:0]                  AXI_AWBURST,
  input  logic                        AXI_AWVALID,
  output logic                        AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0] AXI_WDATA,
  input  logic [C_AXI_STRB_WIDTH-1:0] AXI_WSTRB,
  input  logic                        AXI_WLAST,
  input  logic                        AXI_WVALID,
  output logic                        AXI_WREADY,
  output logic [C_AXI_ID_WIDTH-1:0]   AXI_BID,
  output logic [1:0]                  AXI_BRESP,
  output logic                        AXI_BVALID,
  input  logic                        AXI_BREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]   AXI_ARID,
  input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
  input  logic [C_AXI_LEN_WIDTH-1:0]  AXI_ARLEN,
  input  logic [2:0]                  AXI_ARSIZE,
  input  logic [1:0]                  AXI_ARBURST,
  input  logic                        AXI_ARVALID,
  output logic                        AXI_ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]   AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0] AXI_RDATA,
  output logic [1:0]                  AXI_RRESP,
  output logic                        AXI_RLAST,
  output logic                        AXI_RVALID,
  input  logic                        AXI_RREADY
);

  localparam int LSB    = $clog2(C_AXI_STRB_WIDTH);
  localparam int IDX_W  = C_AXI_ADDR_WIDTH - LSB;
  localparam int RAM_AW = $clog2(MEM_DEPTH);
  localparam int IDW    = C_AXI_ID_WIDTH;
  localparam int LW     = C_AXI_LEN_WIDTH;
  localparam logic [2:0] SIZE_OK = 3'(LSB);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);

  wstate_e          ws_q, ws_d;
  logic [IDW-1:0]   wid_q, wid_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [LW-1:0]    wlen_q, wlen_d;
  logic [LW-1:0]    wbeat_q, wbeat_d;
  logic             wincr_q, wincr_d;
  logic             wcfg_q, wcfg_d;
  logic             werr_q, werr_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;

  rstate_e          rs_q, rs_d;
  logic [IDW-1:0]   rid_q, rid_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [LW-1:0]    rlen_q, rlen_d;
  logic [LW-1:0]    rbeat_q, rbeat_d;
  logic             rincr_q, rincr_d;
  logic             rcfg_q, rcfg_d;
  logic             rerr_q, rerr_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic             rlast_q, rlast_d;

  logic                        w_hs, w_last, w_err, ram_we;
  logic                        ram_re;
  logic [RAM_AW-1:0]           ram_raddr;
  logic [C_AXI_DATA_WIDTH-1:0] ram_rdata;
  logic [IDX_W-1:0]            aw_idx, ar_idx, r_next;
  logic                        ar_cfg;
  logic                        unused_addr_bits;

  assign aw_idx = AXI_AWADDR[C_AXI_ADDR_WIDTH-1:LSB];
  assign ar_idx = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:LSB];
  assign r_next = rincr_q ? ridx_q + 1'b1 : ridx_q;
  assign ar_cfg = cfg_bad(AXI_ARBURST, AXI_ARSIZE, SIZE_OK);
  assign unused_addr_bits =
    ^{AXI_AWADDR[LSB-1:0], AXI_ARADDR[LSB-1:0]};

  assign w_hs   = wready_q & AXI_WVALID;
  assign w_last = (wbeat_q == wlen_q);
  assign w_err  = wcfg_q | (widx_q >= DEPTH_IDX) |
                  (AXI_WLAST != w_last);
  assign ram_we = w_hs & ~w_err;

  always_comb begin
    ws_d      = ws_q;
    wid_d     = wid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    wincr_d   = wincr_q;
    wcfg_d    = wcfg_q;
    werr_d    = werr_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (ws_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (AXI_AWVALID && awready_q) begin
          wid_d     = AXI_AWID;
          widx_d    = aw_idx;
          wlen_d    = AXI_AWLEN;
          wincr_d   = (AXI_AWBURST == BURST_INCR);
          wcfg_d    = cfg_bad(AXI_AWBURST, AXI_AWSIZE, SIZE_OK);
          wbeat_d   = '0;
          werr_d    = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          ws_d      = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          werr_d  = werr_q | w_err;
          wbeat_d = wbeat_q + 1'b1;
          if (wincr_q) widx_d = widx_q + 1'b1;
          // Beat count, not WLAST, ends the burst.
          if (w_last) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (werr_q | w_err) ? RESP_SLVERR : RESP_OKAY;
            ws_d     = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          ws_d      = W_IDLE;
        end
      end
      default: ws_d = W_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
    if (!AXI_ARESET_N) begin
      ws_q      <= W_IDLE;
      wid_q     <= '0;
      widx_q    <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      wincr_q   <= 1'b0;
      wcfg_q    <= 1'b0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      ws_q      <= ws_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      wincr_q   <= wincr_d;
      wcfg_q    <= wcfg_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    rs_d      = rs_q;
    rid_d     = rid_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rincr_d   = rincr_q;
    rcfg_d    = rcfg_q;
    rerr_d    = rerr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    ram_re    = 1'b0;
    ram_raddr = ridx_q[RAM_AW-1:0];
    unique case (rs_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (AXI_ARVALID && arready_q) begin
          rid_d     = AXI_ARID;
          ridx_d    = ar_idx;
          rlen_d    = AXI_ARLEN;
          rincr_d   = (AXI_ARBURST == BURST_INCR);
          rcfg_d    = ar_cfg;
          rbeat_d   = '0;
          rerr_d    = ar_cfg | (ar_idx >= DEPTH_IDX);
          rlast_d   = (AXI_ARLEN == '0);
          ram_re    = 1'b1;
          ram_raddr = ar_idx[RAM_AW-1:0];
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rs_d      = R_DATA;
        end
      end
      R_DATA: begin
        if (AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rerr_d    = 1'b0;
            arready_d = 1'b1;
            rs_d      = R_IDLE;
          end else begin
            ridx_d    = r_next;
            rbeat_d   = rbeat_q + 1'b1;
            rerr_d    = rcfg_q | (r_next >= DEPTH_IDX);
            rlast_d   = ((rbeat_q + 1'b1) == rlen_q);
            ram_re    = 1'b1;
            ram_raddr = r_next[RAM_AW-1:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
    if (!AXI_ARESET_N) begin
      rs_q      <= R_IDLE;
      rid_q     <= '0;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rincr_q   <= 1'b0;
      rcfg_q    <= 1'b0;
      rerr_q    <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      rs_q      <= rs_d;
      rid_q     <= rid_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rincr_q   <= rincr_d;
      rcfg_q    <= rcfg_d;
      rerr_q    <= rerr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  axi_slave_mem_ram #(
    .DW    (C_AXI_DATA_WIDTH),
    .DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk   (AXI_ACLK),
    .rst_n (AXI_ARESET_N),
    .we    (ram_we),
    .waddr (widx_q[RAM_AW-1:0]),
    .wdata (AXI_WDATA),
    .wstrb (AXI_WSTRB),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign AXI_AWREADY = awready_q;
  assign AXI_WREADY  = wready_q;
  assign AXI_BID     = wid_q;
  assign AXI_BRESP   = bresp_q;
  assign AXI_BVALID  = bvalid_q;
  assign AXI_ARREADY = arready_q;
  assign AXI_RID     = rid_q;
  assign AXI_RDATA   = (rvalid_q & ~rerr_q) ? ram_rdata : '0;
  assign AXI_RRESP   = rerr_q ? RESP_SLVERR : RESP_OKAY;
  assign AXI_RLAST   = rlast_q;
  assign AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Bench for axi_slave_mem: vector table, directed corner
// sequences and random traffic against a memory model.
module tb_axi_slave_mem;
  import axi_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  AXI_AWID, AXI_BID, AXI_ARID, AXI_RID;
  logic [31:0] AXI_AWADDR, AXI_ARADDR, AXI_WDATA, AXI_RDATA;
  logic [7:0]  AXI_AWLEN, AXI_ARLEN;
  logic [2:0]  AXI_AWSIZE, AXI_ARSIZE;
  logic [1:0]  AXI_AWBURST, AXI_ARBURST, AXI_BRESP, AXI_RRESP;
  logic [3:0]  AXI_WSTRB;
  logic AXI_AWVALID, AXI_AWREADY, AXI_WLAST, AXI_WVALID, AXI_WREADY;
  logic AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY;
  logic AXI_RLAST, AXI_RVALID, AXI_RREADY;

  axi_slave_mem dut (
    .AXI_ACLK(clk), .AXI_ARESET_N(rst_n),
    .AXI_AWID(AXI_AWID), .AXI_AWADDR(AXI_AWADDR),
    .AXI_AWLEN(AXI_AWLEN), .AXI_AWSIZE(AXI_AWSIZE),
    .AXI_AWBURST(AXI_AWBURST), .AXI_AWVALID(AXI_AWVALID),
    .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB),
    .AXI_WLAST(AXI_WLAST), .AXI_WVALID(AXI_WVALID),
    .AXI_WREADY(AXI_WREADY),
    .AXI_BID(AXI_BID), .AXI_BRESP(AXI_BRESP),
    .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARID(AXI_ARID), .AXI_ARADDR(AXI_ARADDR),
    .AXI_ARLEN(AXI_ARLEN), .AXI_ARSIZE(AXI_ARSIZE),
    .AXI_ARBURST(AXI_ARBURST), .AXI_ARVALID(AXI_ARVALID),
    .AXI_ARREADY(AXI_ARREADY),
    .AXI_RID(AXI_RID), .AXI_RDATA(AXI_RDATA),
    .AXI_RRESP(AXI_RRESP), .AXI_RLAST(AXI_RLAST),
    .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] ed [256];
  logic [1:0]  er [256];

  typedef struct {
    bit          wr;
    logic [9:0]  id;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no handshake within 64 cycles", nm);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({AXI_AWREADY, AXI_WREADY, AXI_BID, AXI_BRESP,
                AXI_BVALID, AXI_ARREADY, AXI_RID, AXI_RDATA,
                AXI_RRESP, AXI_RLAST, AXI_RVALID});
  endfunction

  // Reference: per-beat error rules applied to a word array.
  function automatic logic [1:0] mdl_write(
    input logic [31:0] addr, input int len, input logic [1:0] burst,
    input logic [2:0] size, input int bad);
    int  base, idx;
    bit  cfg, err, any;
    base = int'(addr >> 2);
    cfg  = (burst > 2'd1) || (size != 3'd2);
    any  = 1'b0;
    for (int b = 0; b <= len; b++) begin
      idx = (burst == 2'd1) ? base + b : base;
      err = cfg || idx >= DEPTH || b == bad;
      if (!err)
        for (int k = 0; k < 4; k++)
          if (ws[b][k]) mem_m[idx][8*k +: 8] = wd[b][8*k +: 8];
      any = any | err;
    end
    return any ? 2'b10 : 2'b00;
  endfunction

  function automatic void mdl_read(
    input logic [31:0] addr, input int len, input logic [1:0] burst,
    input logic [2:0] size);
    int base, idx;
    bit cfg, err;
    base = int'(addr >> 2);
    cfg  = (burst > 2'd1) || (size != 3'd2);
    for (int b = 0; b <= len; b++) begin
      idx   = (burst == 2'd1) ? base + b : base;
      err   = cfg || idx >= DEPTH;
      ed[b] = err ? 32'h0 : mem_m[idx];
      er[b] = err ? 2'b10 : 2'b00;
    end
  endfunction

  task automatic do_write(
    input logic [9:0] id, input logic [31:0] addr, input int len,
    input logic [1:0] burst, input logic [2:0] size, input int bad,
    input int gap, input int bstall, input logic [1:0] exp_in,
    input bit use_model);
    logic [1:0]  mresp, exp_r;
    logic [12:0] cap;
    int t;
    mresp = mdl_write(addr, len, burst, size, bad);
    exp_r = use_model ? mresp : exp_in;
    AXI_AWID = id; AXI_AWADDR = addr; AXI_AWLEN = 8'(len);
    AXI_AWBURST = burst; AXI_AWSIZE = size; AXI_AWVALID = 1'b1;
    t = 0;
    while (!AXI_AWREADY && t < 64) begin @(negedge clk); t++; end
    if (!AXI_AWREADY) begin
      tmo("aw_handshake"); AXI_AWVALID = 1'b0; return;
    end
    @(negedge clk);
    AXI_AWVALID = 1'b0;
    chk("wready_after_aw", 64'({AXI_WREADY, AXI_AWREADY}), 64'(2'b10));
    for (int b = 0; b <= len; b++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
      AXI_WDATA = wd[b]; AXI_WSTRB = ws[b];
      AXI_WLAST = (b == len) ^ (b == bad);
      AXI_WVALID = 1'b1;
      t = 0;
      while (!AXI_WREADY && t < 64) begin @(negedge clk); t++; end
      if (!AXI_WREADY) begin
        tmo("w_handshake"); AXI_WVALID = 1'b0; return;
      end
      @(negedge clk);
      AXI_WVALID = 1'b0;
    end
    chk("bvalid_after_last_w", 64'(AXI_BVALID), 64'(1));
    cap = {AXI_BID, AXI_BRESP, AXI_BVALID};
    repeat (bstall) begin
      @(negedge clk);
      chk("b_stable", 64'({AXI_BID, AXI_BRESP, AXI_BVALID}), 64'(cap));
    end
    chk("bid", 64'(AXI_BID), 64'(id));
    chk("bresp", 64'(AXI_BRESP), 64'(exp_r));
    AXI_BREADY = 1'b1;
    @(negedge clk);
    AXI_BREADY = 1'b0;
    chk("b_done", 64'({AXI_BVALID, AXI_AWREADY}), 64'(2'b01));
  endtask

  task automatic do_read(
    input logic [9:0] id, input logic [31:0] addr, input int len,
    input logic [1:0] burst, input logic [2:0] size, input int stall,
    input bit use_model);
    logic [45:0] cap;
    int t;
    if (use_model) mdl_read(addr, len, burst, size);
    AXI_ARID = id; AXI_ARADDR = addr; AXI_ARLEN = 8'(len);
    AXI_ARBURST = burst; AXI_ARSIZE = size; AXI_ARVALID = 1'b1;
    t = 0;
    while (!AXI_ARREADY && t < 64) begin @(negedge clk); t++; end
    if (!AXI_ARREADY) begin
      tmo("ar_handshake"); AXI_ARVALID = 1'b0; return;
    end
    @(negedge clk);
    AXI_ARVALID = 1'b0;
    chk("rvalid_after_ar", 64'({AXI_RVALID, AXI_ARREADY}), 64'(2'b10));
    for (int b = 0; b <= len; b++) begin
      t = 0;
      while (!AXI_RVALID && t < 64) begin @(negedge clk); t++; end
      if (!AXI_RVALID) begin tmo("r_beat"); return; end
      cap = {AXI_RVALID, AXI_RID, AXI_RDATA, AXI_RRESP, AXI_RLAST};
      repeat (stall) begin
        @(negedge clk);
        chk("r_stable", 64'({AXI_RVALID, AXI_RID, AXI_RDATA,
            AXI_RRESP, AXI_RLAST}), 64'(cap));
      end
      chk("rdata", 64'(AXI_RDATA), 64'(ed[b]));
      chk("rresp", 64'(AXI_RRESP), 64'(er[b]));
      chk("rlast", 64'(AXI_RLAST), 64'(b == len));
      chk("rid", 64'(AXI_RID), 64'(id));
      AXI_RREADY = 1'b1;
      @(negedge clk);
      AXI_RREADY = 1'b0;
    end
    chk("r_done", 64'({AXI_RVALID, AXI_ARREADY}), 64'(2'b01));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    AXI_AWID = '0; AXI_AWADDR = '0; AXI_AWLEN = '0;
    AXI_AWSIZE = 3'd2; AXI_AWBURST = 2'b01; AXI_AWVALID = 1'b0;
    AXI_WDATA = '0; AXI_WSTRB = '0; AXI_WLAST = 1'b0;
    AXI_WVALID = 1'b0; AXI_BREADY = 1'b0;
    AXI_ARID = '0; AXI_ARADDR = '0; AXI_ARLEN = '0;
    AXI_ARSIZE = 3'd2; AXI_ARBURST = 2'b01; AXI_ARVALID = 1'b0;
    AXI_RREADY = 1'b0;

    tv[0]  = '{1'b1, 10'd3, 32'h10, 2'b01, 3'd2, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    tv[1]  = '{1'b0, 10'd7, 32'h10, 2'b01, 3'd2, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF};
    tv[2]  = '{1'b0, 10'd1, 32'h13, 2'b01, 3'd2, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF};
    tv[3]  = '{1'b1, 10'd4, 32'h1000, 2'b01, 3'd2, 32'h12345678, 4'hF, 2'b10, 32'h0};
    tv[4]  = '{1'b0, 10'd4, 32'h1000, 2'b01, 3'd2, 32'h0, 4'h0, 2'b10, 32'h0};
    tv[5]  = '{1'b1, 10'd5, 32'h20, 2'b10, 3'd2, 32'h11111111, 4'hF, 2'b10, 32'h0};
    tv[6]  = '{1'b0, 10'd5, 32'h20, 2'b01, 3'd2, 32'h0, 4'h0, 2'b00, 32'hC0DE0008};
    tv[7]  = '{1'b1, 10'd6, 32'h24, 2'b01, 3'd1, 32'h22222222, 4'hF, 2'b10, 32'h0};
    tv[8]  = '{1'b0, 10'd6, 32'h24, 2'b01, 3'd2, 32'h0, 4'h0, 2'b00, 32'hC0DE0009};
    tv[9]  = '{1'b1, 10'd9, 32'h28, 2'b01, 3'd2, 32'hAAAABBBB, 4'h3, 2'b00, 32'h0};
    tv[10] = '{1'b0, 10'd9, 32'h28, 2'b01, 3'd2, 32'h0, 4'h0, 2'b00, 32'hC0DEBBBB};
    tv[11] = '{1'b0, 10'd2, 32'h10, 2'b11, 3'd2, 32'h0, 4'h0, 2'b10, 32'h0};
    tv[12] = '{1'b0, 10'h3FF, 32'h10, 2'b00, 3'd2, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF};
    tv[13] = '{1'b0, 10'd8, 32'h28, 2'b01, 3'd0, 32'h0, 4'h0, 2'b10, 32'h0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known contents for words 0..127.
    for (int i = 0; i < 128; i++) begin
      wd[i] = 32'hC0DE0000 + 32'(i); ws[i] = 4'hF;
    end
    do_write(10'd0, 32'h0, 127, 2'b01, 3'd2, -1, 0, 0, 2'b00, 1'b0);

    for (int i = 0; i < 14; i++) begin
      if (tv[i].wr) begin
        wd[0] = tv[i].data; ws[0] = tv[i].strb;
        do_write(tv[i].id, tv[i].addr, 0, tv[i].burst, tv[i].size,
                 -1, 0, 1, tv[i].resp, 1'b0);
      end else begin
        ed[0] = tv[i].rdata; er[0] = tv[i].resp;
        do_read(tv[i].id, tv[i].addr, 0, tv[i].burst, tv[i].size,
                1, 1'b0);
      end
    end

    // INCR burst then a single-byte overwrite.
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1); ws[i] = 4'hF;
    end
    do_write(10'd2, 32'h0, 3, 2'b01, 3'd2, -1, 0, 0, 2'b00, 1'b0);
    wd[0] = 32'hFF; ws[0] = 4'h1;
    do_write(10'd2, 32'h4, 0, 2'b01, 3'd2, -1, 0, 0, 2'b00, 1'b0);
    ed[0] = 32'h1; ed[1] = 32'hFF; ed[2] = 32'h3; ed[3] = 32'h4;
    for (int i = 0; i < 4; i++) er[i] = 2'b00;
    do_read(10'd2, 32'h0, 3, 2'b01, 3'd2, 0, 1'b0);

    // FIXED burst keeps only the last beat.
    wd[0] = 32'hA; wd[1] = 32'hB; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(10'd1, 32'h8, 1, 2'b00, 3'd2, -1, 0, 0, 2'b00, 1'b0);
    ed[0] = 32'hB; er[0] = 2'b00;
    do_read(10'd1, 32'h8, 0, 2'b01, 3'd2, 0, 1'b0);

    // Early WLAST on beat 0 errs only that beat.
    wd[0] = 32'h55; wd[1] = 32'h66;
    do_write(10'd3, 32'h30, 1, 2'b01, 3'd2, 0, 0, 0, 2'b10, 1'b0);
    ed[0] = 32'hC0DE000C; ed[1] = 32'h66; er[0] = 2'b00; er[1] = 2'b00;
    do_read(10'd3, 32'h30, 1, 2'b01, 3'd2, 0, 1'b0);

    // INCR crossing the top of memory.
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'h10 + 32'(i); ws[i] = 4'hF;
    end
    do_write(10'd4, 32'hFF8, 3, 2'b01, 3'd2, -1, 0, 0, 2'b10, 1'b0);
    ed[0] = 32'h10; ed[1] = 32'h11; ed[2] = 32'h0; ed[3] = 32'h0;
    er[0] = 2'b00; er[1] = 2'b00; er[2] = 2'b10; er[3] = 2'b10;
    do_read(10'd4, 32'hFF8, 3, 2'b01, 3'd2, 0, 1'b0);

    // Stalled read: three beats held five cycles each.
    ed[0] = 32'h1; ed[1] = 32'hFF; ed[2] = 32'hB;
    for (int i = 0; i < 3; i++) er[i] = 2'b00;
    do_read(10'd6, 32'h0, 2, 2'b01, 3'd2, 5, 1'b0);

    // Concurrent write and read on different words.
    wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
    ed[0] = 32'hC0DE0029; er[0] = 2'b00;
    fork
      do_write(10'd7, 32'hA0, 0, 2'b01, 3'd2, -1, 0, 0, 2'b00, 1'b0);
      do_read(10'd8, 32'hA4, 0, 2'b01, 3'd2, 0, 1'b0);
    join

    // Reset in the middle of a write burst.
    AXI_AWID = 10'd5; AXI_AWADDR = 32'h200; AXI_AWLEN = 8'd3;
    AXI_AWBURST = 2'b01; AXI_AWSIZE = 3'd2; AXI_AWVALID = 1'b1;
    for (int t = 0; t < 64 && !AXI_AWREADY; t++) @(negedge clk);
    @(negedge clk);
    AXI_AWVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      AXI_WDATA = 32'h900 + 32'(b); AXI_WSTRB = 4'hF;
      AXI_WLAST = 1'b0; AXI_WVALID = 1'b1;
      @(negedge clk);
    end
    AXI_WVALID = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_burst", all_outs(), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wd[0] = 32'h77; ws[0] = 4'hF;
    do_write(10'd5, 32'h204, 0, 2'b01, 3'd2, -1, 0, 0, 2'b00, 1'b0);
    ed[0] = 32'h77; er[0] = 2'b00;
    do_read(10'd5, 32'h204, 0, 2'b01, 3'd2, 0, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      bit          wr;
      int          base, len, bad;
      logic [1:0]  burst;
      logic [2:0]  size;
      logic [31:0] addr;
      wr    = 1'($urandom_range(0, 1));
      base  = ($urandom_range(0, 15) == 0) ? 1030 : int'($urandom_range(0, 63));
      len   = int'($urandom_range(0, 7));
      burst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3))
                                          : 2'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      bad   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
      addr  = 32'(base * 4) + 32'($urandom_range(0, 3));
      if (wr) begin
        for (int b = 0; b <= len; b++) begin
          wd[b] = $urandom; ws[b] = 4'($urandom_range(0, 15));
        end
        do_write(10'($urandom_range(0, 1023)), addr, len, burst, size,
                 bad, 2, int'($urandom_range(0, 2)), 2'b00, 1'b1);
      end else begin
        do_read(10'($urandom_range(0, 1023)), addr, len, burst, size,
                int'($urandom_range(0, 2)), 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

Synthesizable AXI slave memory model that sits directly downstream of the AXI virtual interface. It consumes master-driven AW/W/AR/B-ready/R-ready signals and produces the slave-side responses, so the interface's X/Z assertions run against a real responder. Write and read channels run independent FSMs, one outstanding transaction each, over a word-addressed byte-enabled RAM.

## Interface
- C_AXI_ID_WIDTH, 10, ID width for AW/B/AR/R
- C_AXI_ADDR_WIDTH, 32, byte address width
- C_AXI_DATA_WIDTH, 32, data width; C_AXI_STRB_WIDTH = C_AXI_DATA_WIDTH/8
- C_AXI_LEN_WIDTH, 8, burst length field width (beats = LEN+1)
- MEM_DEPTH, 1024, RAM depth in data words (power of two)

Ports:
- AXI_ACLK  in  1  clock, all logic on rising edge
- AXI_ARESET_N  in  1  asynchronous, active-low reset
- AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  ID/ADDR/LEN/3/2/1  write address
- AXI_AWREADY  out  1
- AXI_WDATA/WSTRB/WLAST/WVALID  in  DATA/STRB/1/1  write data
- AXI_WREADY  out  1
- AXI_BID/BRESP/BVALID  out  ID/2/1  write response; AXI_BREADY  in  1
- AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  ID/ADDR/LEN/3/2/1  read address
- AXI_ARREADY  out  1
- AXI_RID/RDATA/RRESP/RLAST/RVALID  out  ID/DATA/2/1/1  read data; AXI_RREADY  in  1

## Operation
- Reset: all outputs 0; both FSMs to IDLE; RAM contents not reset. Reset mid-burst abandons the transaction, no response issued.
- Word index = ADDR >> log2(STRB_WIDTH); low address bits ignored.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1; on AWVALID capture ID, word index, LEN, BURST, SIZE; beat count=0; error flag cleared.
  - W_DATA: WREADY=1; each W handshake writes bytes where WSTRB=1; INCR advances index by 1, FIXED holds it. After LEN+1 beats go W_RESP.
  - W_RESP: BVALID=1, BID=captured ID, BRESP=OKAY(00) or SLVERR(10); held until BREADY, then W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1; on ARVALID capture fields, load RDATA for beat 0, go R_DATA.
  - R_DATA: RVALID=1, RID=captured ID, RLAST=1 on beat LEN; on RREADY load next beat; after last beat return to R_IDLE.
- SLVERR sources: word index >= MEM_DEPTH (per beat), BURST=WRAP or reserved, SIZE != log2(STRB_WIDTH), WLAST value mismatching beat position. Erroneous write beats do not modify RAM; erroneous read beats return RDATA=0, RRESP=10. Write BRESP is sticky SLVERR if any beat erred.
- INCR index is not wrapped; crossing MEM_DEPTH errs remaining beats.

## Timing
- AW/AR accepted in cycle N -> WREADY / RVALID asserted from N+1.
- Last W beat at N -> BVALID at N+1. Minimum write = LEN+3 cycles, read = LEN+2 cycles with ready held high.
- R outputs are registered and stable while RVALID & !RREADY; B outputs likewise.
- Same-cycle RAM write and RDATA load to same word: RDATA gets pre-write contents.
- AWREADY/ARREADY low outside IDLE; write and read channels fully concurrent.

## Structure
- Shared axi_pkg: burst enum (FIXED=00, INCR=01, WRAP=10), resp constants (OKAY=00, SLVERR=10), write/read state enums.
- Sub-module axi_slave_mem_ram: 1 write port with byte enables, 1 read port, registered read-load strobe.

## Test plan
- Single write ID=3, addr 0x10, data 0xDEADBEEF, strb 0xF -> BID=3, BRESP=00; read addr 0x10 -> RDATA=0xDEADBEEF, RLAST=1, RRESP=00.
- INCR write LEN=3 at 0x0 data 1..4, then strb 0x1 overwrite 0xFF at 0x4 -> INCR read LEN=3 returns 1, 0x000000FF, 3, 4, RLAST only on 4th beat.
- FIXED write LEN=1 at 0x8 data 0xA,0xB -> read 0x8 returns 0xB.
- Write to word 1024 (addr 0x1000) -> BRESP=10, RAM unchanged; read there -> RDATA=0, RRESP=10.
- Read LEN=2 with RREADY held low 5 cycles per beat -> RDATA/RID/RLAST stable while stalled, 3 beats total.
- Assert AXI_ARESET_N low mid write burst -> all outputs 0, next AW accepted normally with BRESP=00.
